// File: rtl/ce_pipe_if.sv
// ce_pipe_if -- handshake/data bundle for the ce_pipe elastic buffer.
//   Upstream  : Send_in (req, active-low), D_in, Ack_out (ack, active-low)
//   Downstream: Send_out (req, active-low), D_out, Ack_in (ack, active-low)
//   Control   : Exb (per-stage entry enable, active-low block)
//   Status    : CP (per-stage capture pulse), Count (full stages)
// Modport slave is the pipe's view; master is the driving environment's view.
interface ce_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) ();
  logic             Send_in;
  logic [WIDTH-1:0] D_in;
  logic             Ack_out;
  logic             Send_out;
  logic [WIDTH-1:0] D_out;
  logic             Ack_in;
  logic [DEPTH-1:0] Exb;
  logic [DEPTH-1:0] CP;
  logic [CNTW-1:0]  Count;

  modport slave (
    input  Send_in, D_in, Ack_in, Exb,
    output Ack_out, Send_out, D_out, CP, Count
  );

  modport master (
    output Send_in, D_in, Ack_in, Exb,
    input  Ack_out, Send_out, D_out, CP, Count
  );
endinterface

// File: rtl/ce_pipe.sv
// ce_pipe -- DEPTH-stage clocked elastic buffer with active-low 4-phase
// Send/Ack handshakes on both ends, per-stage capture pulses and per-stage
// entry blocking.
//   CLK : clock, all state changes on the rising edge
//   MRb : synchronous active-low master reset
//   bus : ce_pipe_if.slave -- Send_in/D_in/Ack_out upstream,
//         Send_out/D_out/Ack_in downstream, Exb entry enables,
//         CP capture pulses, Count occupancy
module ce_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic    CLK,
  input  logic    MRb,
  ce_pipe_if.slave bus
);

  logic [DEPTH-1:0] full_q, full_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             in_wait_q, in_wait_d;
  logic             out_wait_q, out_wait_d;
  logic [DEPTH-1:0] cp_q, cp_d;
  logic [CNTW-1:0]  count_q, count_d;

  logic [DEPTH-1:0] move;    // token in stage i leaves at this edge
  logic [DEPTH-1:0] cap;     // stage i captures at this edge
  logic             accept;
  logic             out_valid;

  assign out_valid = full_q[DEPTH-1] & ~out_wait_q;

  // Move chain is resolved from the output stage backwards so a fully
  // packed pipe shifts every token on the edge it drains.
  always_comb begin
    move          = '0;
    move[DEPTH-1] = out_valid & ~bus.Ack_in;
    for (int unsigned i = DEPTH - 1; i > 0; i--) begin
      move[i-1] = full_q[i-1] & bus.Exb[i] & (~full_q[i] | move[i]);
    end
  end

  assign accept = ~bus.Send_in & ~in_wait_q & bus.Exb[0] & (~full_q[0] | move[0]);

  always_comb begin
    cap    = '0;
    cap[0] = accept;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      cap[i] = move[i-1];
    end
  end

  always_comb begin
    full_d    = (full_q & ~move) | cap;
    data_d[0] = cap[0] ? bus.D_in : data_q[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      data_d[i] = cap[i] ? data_q[i-1] : data_q[i];
    end
    cp_d       = cap;
    // Phase flags hold until the peer returns its line high (4-phase).
    in_wait_d  = accept | (in_wait_q & ~bus.Send_in);
    out_wait_d = move[DEPTH-1] | (out_wait_q & ~bus.Ack_in);
    unique case ({accept, move[DEPTH-1]})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!MRb) begin
      full_q     <= '0;
      in_wait_q  <= 1'b0;
      out_wait_q <= 1'b0;
      cp_q       <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q     <= full_d;
      in_wait_q  <= in_wait_d;
      out_wait_q <= out_wait_d;
      cp_q       <= cp_d;
      count_q    <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.Ack_out  = ~in_wait_q;
  assign bus.Send_out = ~out_valid;
  assign bus.D_out    = data_q[DEPTH-1];
  assign bus.CP       = cp_q;
  assign bus.Count    = count_q;

endmodule

// File: tb/tb_ce_pipe.sv
// tb_ce_pipe -- directed scenarios followed by randomized traffic, every
// cycle compared against a token-list reference model.
module tb_ce_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);

  logic CLK = 1'b0;
  logic MRb;

  ce_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  ce_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK (CLK),
    .MRb (MRb),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: a list of tokens, oldest first, each with its stage.
  int unsigned      m_pos [$];
  logic [WIDTH-1:0] m_dat [$];
  bit               m_inw  = 1'b0;
  bit               m_outw = 1'b0;
  logic [DEPTH-1:0] m_cp   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_send_valid();
    return (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1) && !m_outw;
  endfunction

  task automatic model_edge();
    logic [DEPTH-1:0] ncp;
    bit drain, acc;
    if (MRb !== 1'b1) begin
      m_pos.delete();
      m_dat.delete();
      m_inw  = 1'b0;
      m_outw = 1'b0;
      m_cp   = '0;
    end else begin
      ncp   = '0;
      drain = m_send_valid() && (bus.Ack_in == 1'b0);
      if (drain) begin
        void'(m_pos.pop_front());
        void'(m_dat.pop_front());
      end
      for (int k = 0; k < m_pos.size(); k++) begin
        int unsigned p;
        p = m_pos[k];
        if (p < DEPTH - 1 && bus.Exb[p+1] == 1'b1 && (k == 0 || m_pos[k-1] != p + 1)) begin
          m_pos[k]  = p + 1;
          ncp[p+1]  = 1'b1;
        end
      end
      acc = (bus.Send_in == 1'b0) && !m_inw && (bus.Exb[0] == 1'b1) &&
            (m_pos.size() == 0 || m_pos[m_pos.size()-1] != 0);
      if (acc) begin
        m_pos.push_back(0);
        m_dat.push_back(bus.D_in);
        ncp[0] = 1'b1;
      end
      m_inw  = acc || (m_inw && bus.Send_in == 1'b0);
      m_outw = drain || (m_outw && bus.Ack_in == 1'b0);
      m_cp   = ncp;
    end
  endtask

  task automatic compare();
    chk("ack_out",  32'(bus.Ack_out),  32'(!m_inw));
    chk("send_out", 32'(bus.Send_out), 32'(!m_send_valid()));
    chk("cp",       32'(bus.CP),       32'(m_cp));
    chk("count",    32'(bus.Count),    32'(m_pos.size()));
    if (m_send_valid()) chk("d_out", 32'(bus.D_out), 32'(m_dat[0]));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare();
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    for (int n = 0; n < 20 && bus.Ack_out !== lvl; n++) step();
    chk(tag, 32'(bus.Ack_out), 32'(lvl));
  endtask

  task automatic send_tok(input logic [WIDTH-1:0] v);
    bus.Send_in = 1'b0;
    bus.D_in    = v;
    step();
    wait_ack(1'b0, "send_accept");
    bus.Send_in = 1'b1;
    step();
    wait_ack(1'b1, "send_release");
  endtask

  task automatic drain_expect(input logic [WIDTH-1:0] v);
    for (int n = 0; n < 20 && bus.Send_out !== 1'b0; n++) step();
    chk("drain_ready", 32'(bus.Send_out), 32'd0);
    chk("drain_data",  32'(bus.D_out),    32'(v));
    bus.Ack_in = 1'b0;
    step();
    chk("drain_send_hi", 32'(bus.Send_out), 32'd1);
    bus.Ack_in = 1'b1;
    step();
  endtask

  initial begin
    MRb         = 1'b0;
    bus.Send_in = 1'b0;
    bus.Ack_in  = 1'b0;
    bus.Exb     = '1;
    bus.D_in    = '0;

    // Reset held for three edges with both requests asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack_out",  32'(bus.Ack_out),  32'd1);
      chk("rst_send_out", 32'(bus.Send_out), 32'd1);
      chk("rst_cp",       32'(bus.CP),       32'd0);
      chk("rst_count",    32'(bus.Count),    32'd0);
    end

    // Single token walks through all four stages.
    MRb        = 1'b1;
    bus.D_in   = 8'hA5;
    bus.Ack_in = 1'b1;
    step();
    chk("single_cp0", 32'(bus.CP), 32'h1);
    chk("single_ack", 32'(bus.Ack_out), 32'd0);
    bus.Send_in = 1'b1;
    step();
    chk("single_cp1", 32'(bus.CP), 32'h2);
    step();
    chk("single_cp2", 32'(bus.CP), 32'h4);
    step();
    chk("single_cp3",   32'(bus.CP),       32'h8);
    chk("single_send",  32'(bus.Send_out), 32'd0);
    chk("single_dout",  32'(bus.D_out),    32'hA5);
    chk("single_count", 32'(bus.Count),    32'd1);
    bus.Ack_in = 1'b0;
    step();
    chk("single_drained", 32'(bus.Send_out), 32'd1);
    chk("single_count0",  32'(bus.Count),    32'd0);
    bus.Ack_in = 1'b1;
    step();

    // Fill with the output stalled; fifth token waits for a drain.
    for (int v = 1; v <= 4; v++) send_tok(WIDTH'(v));
    bus.Send_in = 1'b0;
    bus.D_in    = 8'h05;
    repeat (6) step();
    chk("fill_stall_ack", 32'(bus.Ack_out), 32'd1);
    chk("fill_count",     32'(bus.Count),   32'd4);
    drain_expect(8'h01);
    wait_ack(1'b0, "fill_fifth_accept");
    bus.Send_in = 1'b1;
    step();
    for (int v = 2; v <= 5; v++) drain_expect(WIDTH'(v));
    chk("fill_empty", 32'(bus.Count), 32'd0);

    // Entry to stage 2 blocked while the token sits in stage 1.
    bus.Send_in = 1'b0;
    bus.D_in    = 8'h3C;
    step();
    bus.Send_in = 1'b1;
    bus.Exb     = 4'b1011;
    step();
    chk("exb_in_stage1", 32'(bus.CP), 32'h2);
    step();
    chk("exb_hold_cp2", 32'(bus.CP[2]), 32'd0);
    step();
    chk("exb_hold_cp", 32'(bus.CP), 32'd0);
    bus.Exb = '1;
    step();
    chk("exb_release_cp", 32'(bus.CP), 32'h4);
    drain_expect(8'h3C);

    // Packed pipe: accept and drain on the same edge.
    for (int v = 8'h11; v <= 8'h14; v++) send_tok(WIDTH'(v));
    repeat (4) step();
    chk("simul_full", 32'(bus.Count), 32'd4);
    bus.Send_in = 1'b0;
    bus.D_in    = 8'h15;
    bus.Ack_in  = 1'b0;
    step();
    chk("simul_count", 32'(bus.Count),    32'd4);
    chk("simul_cp",    32'(bus.CP),       32'hF);
    chk("simul_ack",   32'(bus.Ack_out),  32'd0);
    chk("simul_send",  32'(bus.Send_out), 32'd1);
    bus.Send_in = 1'b1;
    bus.Ack_in  = 1'b1;
    step();
    chk("simul_next_send", 32'(bus.Send_out), 32'd0);
    chk("simul_next_dout", 32'(bus.D_out),    32'h12);

    // Reset with three tokens held and the output presenting.
    bus.Ack_in = 1'b0;
    step();
    bus.Ack_in = 1'b1;
    step();
    chk("mid_count3", 32'(bus.Count),    32'd3);
    chk("mid_send",   32'(bus.Send_out), 32'd0);
    MRb = 1'b0;
    step();
    chk("mid_rst_ack",   32'(bus.Ack_out),  32'd1);
    chk("mid_rst_send",  32'(bus.Send_out), 32'd1);
    chk("mid_rst_dout",  32'(bus.D_out),    32'd0);
    chk("mid_rst_cp",    32'(bus.CP),       32'd0);
    chk("mid_rst_count", 32'(bus.Count),    32'd0);
    MRb = 1'b1;
    step();

    // Randomized traffic, occasional blocking and reset.
    for (int c = 0; c < 3000; c++) begin
      MRb         = ($urandom_range(0, 199) != 0);
      bus.Send_in = 1'($urandom_range(0, 1));
      bus.Ack_in  = 1'($urandom_range(0, 1));
      bus.Exb     = ($urandom_range(0, 3) == 0) ? DEPTH'($urandom) : '1;
      bus.D_in    = WIDTH'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ce_pipe.md
# ce_pipe

Parametrised, clocked successor to the single C-element handshake stage. It chains DEPTH data-carrying stages between an active-low Send/Ack 4-phase upstream port and an identical downstream port. Each stage emits a capture pulse (CP) and can be individually frozen through its active-low Exb line. It sits between DDP functional units wherever a multi-token elastic buffer with per-stage hold control is needed.

## Interface
- WIDTH, 8, data bits per token
- DEPTH, 4, number of stages (≥1)
- CNTW, $clog2(DEPTH+1), width of Count
- CLK  in  1  clock; all state updates on rising edge
- MRb  in  1  master reset; synchronous, active-low
- Send_in  in  1  upstream request, active-low
- D_in  in  WIDTH  upstream data, valid while Send_in=0
- Ack_out  out  1  upstream acknowledge, active-low
- Send_out  out  1  downstream request, active-low
- D_out  out  WIDTH  contents of stage DEPTH-1
- Ack_in  in  1  downstream acknowledge, active-low
- Exb  in  DEPTH  Exb[i]=0 blocks entry into stage i
- CP  out  DEPTH  CP[i]=1 for one cycle after stage i captures
- Count  out  CNTW  number of full stages

## Operation
- State: full[i] and data[i] per stage; in_wait and out_wait phase flags; CP register.
- Reset (MRb=0 at an edge): clear full, data, in_wait, out_wait and CP. Result: Ack_out=1, Send_out=1, D_out=0, CP=0, Count=0. Reset mid-transfer drops all tokens; no handshake completes.
- Ack_out = ~in_wait.
- Send_out = ~(full[DEPTH-1] & ~out_wait).
- D_out = data[DEPTH-1]; only meaningful while Send_out=0.
- Input accept = Send_in==0 & ~in_wait & Exb[0] & (~full[0] | move[0]). On accept: data[0]<=D_in, full[0]<=1, in_wait<=1, CP[0]<=1.
- in_wait clears at the first edge sampling Send_in=1. Back-to-back tokens therefore need Send_in to return to 1 (4-phase).
- move[DEPTH-1] = (Send_out==0 & Ack_in==0). On it: full[DEPTH-1] clears unless refilled the same edge, and out_wait<=1.
- out_wait clears at the first edge sampling Ack_in=1.
- For i<DEPTH-1: move[i] = full[i] & Exb[i+1] & (~full[i+1] | move[i+1]). On move[i]: data[i+1]<=data[i], full[i+1]<=1, CP[i+1]<=1, and full[i] clears unless refilled the same edge.
- The move chain resolves from the output backwards within a cycle. A fully packed pipe advances every token on the same edge it drains.
- Exb[i]=0 stops stage i from capturing; its current token stays and may still leave. It does not clear CP or full.
- Stage DEPTH-1 may refill while out_wait=1, but Send_out stays 1 until out_wait clears.
- CP[i] is 0 in any cycle where stage i did not capture at the preceding edge.
- Count is registered and updated each edge: +1 on accept, −1 on move[DEPTH-1], unchanged if both occur. Range 0..DEPTH; never wraps.

## Timing
- Accept sampled at edge k → Ack_out=0 and CP[0]=1 after edge k.
- Unblocked token reaches stage i after edge k+i, with CP[i]=1 for that cycle. Send_out=0 after edge k+DEPTH-1.
- Ack_in=0 sampled at edge m (with Send_out=0) → Send_out=1 after edge m. Next Send_out=0 no earlier than the cycle after Ack_in=1 is sampled.
- Input throughput is at most one token per 2 cycles (4-phase return). Internal stages impose no bubbles.
- Simultaneous accept and drain with the pipe full: both occur, Count unchanged.

## Test plan
- Reset: MRb=0 for 3 cycles with Send_in=0, Ack_in=0 → Ack_out=1, Send_out=1, CP=0, Count=0 throughout; first accept at the first edge with MRb=1.
- Single token, DEPTH=4: D_in=0xA5, Send_in low at edge 0, Ack_in=1 → CP[0..3] pulse after edges 0..3; Send_out=0 after edge 3 with D_out=0xA5.
  - Then Ack_in=0 → Send_out=1 next cycle, Count 1→0.
- Fill: hold Ack_in=1 and send 0x01..0x05 with 4-phase input → first four accepted, Count=4; fifth stalls with Ack_out=1 until one drains.
  - Drain order must be 0x01..0x04, then 0x05.
- Exb hold: Exb[2]=0 while token 0x3C is in stage 1 → token stays in stage 1, CP[2]=0.
  - Release Exb[2]=1 → CP[2] pulses the next cycle and the token continues.
- Full-pipe simultaneity: pipe full with Send_in=0 and Ack_in=0 at the same edge → output drains, all tokens shift, new token enters stage 0, Count stays 4.
- Reset mid-operation: MRb=0 while Count=3 and Send_out=0 → after that edge all outputs take their reset values; the tokens are lost.
